// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg: shared payload layout and default widths for the MEM/WB stage.
package mem_wb_pkg;
  localparam int XLEN_D = 64;
  localparam int REG_AW_D = 5;
  typedef struct packed {
    logic                regwrite;
    logic                memtoreg;
    logic [XLEN_D-1:0]   readdata;
    logic [XLEN_D-1:0]   aluresult;
    logic [REG_AW_D-1:0] rd;
  } wb_payload_t;
  function automatic int payload_w(int xlen, int aw);
    return 2 + 2 * xlen + aw;
  endfunction
endpackage

// File: rtl/mem_wb_if.sv
// mem_wb_if: upstream and write-back handshake/bus signals of the MEM/WB stage.
interface mem_wb_if #(
  parameter int XLEN   = mem_wb_pkg::XLEN_D,
  parameter int REG_AW = mem_wb_pkg::REG_AW_D
);
  logic              in_valid;
  logic              in_ready;
  logic              in_regwrite;
  logic              in_memtoreg;
  logic [XLEN-1:0]   in_readdata;
  logic [XLEN-1:0]   in_aluresult;
  logic [REG_AW-1:0] in_rd;
  logic              out_valid;
  logic              out_ready;
  logic              out_regwrite;
  logic              out_memtoreg;
  logic [XLEN-1:0]   out_readdata;
  logic [XLEN-1:0]   out_aluresult;
  logic [REG_AW-1:0] out_rd;
  logic [XLEN-1:0]   out_wb_data;
  modport slave (
    input  in_valid, in_regwrite, in_memtoreg, in_readdata, in_aluresult, in_rd, out_ready,
    output in_ready, out_valid, out_regwrite, out_memtoreg, out_readdata, out_aluresult, out_rd,
           out_wb_data
  );
  modport master (
    output in_valid, in_regwrite, in_memtoreg, in_readdata, in_aluresult, in_rd, out_ready,
    input  in_ready, out_valid, out_regwrite, out_memtoreg, out_readdata, out_aluresult, out_rd,
           out_wb_data
  );
endinterface

// File: rtl/mem_wb_skid_stage_pipe_skid_buf.sv
// pipe_skid_buf: generic valid/ready register with a one-entry skid buffer and flush.
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);
  logic         main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic [W-1:0] main_q, main_d, skid_q, skid_d;
  logic         accept, drain;
  assign in_ready_o  = ~skid_v_q;
  assign accept      = in_valid_i & ~skid_v_q;
  assign drain       = main_v_q & out_ready_i;
  assign out_valid_o = main_v_q;
  assign out_data_o  = main_q;
  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d   = main_q;
    skid_d   = skid_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (skid_v_q) begin
      if (drain) begin
        main_d   = skid_q;
        skid_v_d = 1'b0;
      end
    end else if (!main_v_q || drain) begin
      main_v_d = accept;
      if (accept) main_d = in_data_i;
    end else if (accept) begin
      skid_v_d = 1'b1;
      skid_d   = in_data_i;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
    end
  end
endmodule

// File: rtl/mem_wb_skid_stage.sv
// mem_wb_skid_stage: MEM/WB register with skid buffer, x0 suppression and write-back mux.
// Define MEM_WB_STATS_EN to add saturating stall/bubble counters.
module mem_wb_skid_stage
  import mem_wb_pkg::*;
#(
  parameter int XLEN              = XLEN_D,
  parameter int REG_AW            = REG_AW_D,
  parameter bit ZERO_REG_SUPPRESS = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  mem_wb_if.slave     bus
`ifdef MEM_WB_STATS_EN
  ,
  output logic [31:0] stat_stall_cnt,
  output logic [31:0] stat_bubble_cnt
`endif
);
  localparam int W = payload_w(XLEN, REG_AW);
  logic [W-1:0]      in_pl, out_pl;
  logic              cap_rw, out_valid, pl_rw, pl_mtr;
  logic [XLEN-1:0]   pl_rdata, pl_alu;
  logic [REG_AW-1:0] pl_rd;
  assign cap_rw = bus.in_regwrite & ~(ZERO_REG_SUPPRESS & (bus.in_rd == '0));
  assign in_pl  = {cap_rw, bus.in_memtoreg, bus.in_readdata, bus.in_aluresult, bus.in_rd};
  pipe_skid_buf #(.W(W)) u_skid (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid_i  (bus.in_valid),
    .in_ready_o  (bus.in_ready),
    .in_data_i   (in_pl),
    .out_valid_o (out_valid),
    .out_ready_i (bus.out_ready),
    .out_data_o  (out_pl)
  );
  assign {pl_rw, pl_mtr, pl_rdata, pl_alu, pl_rd} = out_pl;
  // Control bits are masked so a bubble never writes back, even with stale payload.
  assign bus.out_valid     = out_valid;
  assign bus.out_regwrite  = out_valid & pl_rw;
  assign bus.out_memtoreg  = out_valid & pl_mtr;
  assign bus.out_readdata  = pl_rdata;
  assign bus.out_aluresult = pl_alu;
  assign bus.out_rd        = pl_rd;
  assign bus.out_wb_data   = (out_valid & pl_mtr) ? pl_rdata : pl_alu;
`ifdef MEM_WB_STATS_EN
  logic [31:0] stall_q, stall_d, bubble_q, bubble_d;
  always_comb begin
    stall_d  = (out_valid && !bus.out_ready && !(&stall_q)) ? stall_q + 32'd1 : stall_q;
    bubble_d = (!out_valid && !(&bubble_q)) ? bubble_q + 32'd1 : bubble_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end
  assign stat_stall_cnt  = stall_q;
  assign stat_bubble_cnt = bubble_q;
`endif
endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// tb_mem_wb_skid_stage: directed stimulus with a scoreboard queue checked by a write-back monitor.
module tb_mem_wb_skid_stage;
  import mem_wb_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  int errors = 0;
  int checks = 0;
  wb_payload_t exp_q[$];
  wb_payload_t e;
  mem_wb_if #(.XLEN(64), .REG_AW(5)) bus ();
`ifdef MEM_WB_STATS_EN
  logic [31:0] stall_cnt, bubble_cnt;
`endif
  mem_wb_skid_stage #(.XLEN(64), .REG_AW(5), .ZERO_REG_SUPPRESS(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave)
`ifdef MEM_WB_STATS_EN
    ,
    .stat_stall_cnt  (stall_cnt),
    .stat_bubble_cnt (bubble_cnt)
`endif
  );
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic send(input logic rw, input logic mtr, input logic [4:0] rd,
                      input logic [63:0] rdata, input logic [63:0] alu);
    int n = 0;
    bus.in_valid     = 1'b1;
    bus.in_regwrite  = rw;
    bus.in_memtoreg  = mtr;
    bus.in_rd        = rd;
    bus.in_readdata  = rdata;
    bus.in_aluresult = alu;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: rd=%0d in_ready stayed 0, required 1", rd);
    end else begin
      exp_q.push_back('{regwrite: rw & (rd != 5'd0), memtoreg: mtr, readdata: rdata,
                        aluresult: alu, rd: rd});
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (!bus.out_valid) begin
        check("bubble_regwrite", {63'd0, bus.out_regwrite}, 64'd0);
      end else if (bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: rd=%0d emitted, required no output", bus.out_rd);
        end else begin
          e = exp_q.pop_front();
          check("out_rd", {59'd0, bus.out_rd}, {59'd0, e.rd});
          check("out_regwrite", {63'd0, bus.out_regwrite}, {63'd0, e.regwrite});
          check("out_memtoreg", {63'd0, bus.out_memtoreg}, {63'd0, e.memtoreg});
          check("out_wb_data", bus.out_wb_data, e.memtoreg ? e.readdata : e.aluresult);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.in_valid     = 1'b1;
    bus.in_regwrite  = 1'b1;
    bus.in_memtoreg  = 1'b0;
    bus.in_rd        = 5'd9;
    bus.in_readdata  = 64'd0;
    bus.in_aluresult = 64'h99;
    bus.out_ready    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_out_regwrite", {63'd0, bus.out_regwrite}, 64'd0);
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("rst_wb_data", bus.out_wb_data, 64'd0);
    reset = 1'b0;
    send(1'b1, 1'b0, 5'd9, 64'd0, 64'h99);
    check("first_accept_valid", {63'd0, bus.out_valid}, 64'd1);
    check("first_accept_rd", {59'd0, bus.out_rd}, 64'd9);
    for (int i = 1; i <= 4; i++) begin
      send(1'b1, 1'b0, 5'(i), 64'd0, 64'(i * 16));
      check("stream_valid", {63'd0, bus.out_valid}, 64'd1);
      check("stream_rd", {59'd0, bus.out_rd}, 64'(i));
      check("stream_wb_data", bus.out_wb_data, 64'(i * 16));
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(1'b1, 1'b0, 5'd5, 64'd0, 64'h50);
    send(1'b1, 1'b0, 5'd6, 64'd0, 64'h60);
    check("bp_in_ready_full", {63'd0, bus.in_ready}, 64'd0);
    check("bp_hold_rd", {59'd0, bus.out_rd}, 64'd5);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_skid_to_main_rd", {59'd0, bus.out_rd}, 64'd6);
    check("bp_in_ready_again", {63'd0, bus.in_ready}, 64'd1);
    send(1'b1, 1'b0, 5'd7, 64'd0, 64'h70);
    check("bp_c_rd", {59'd0, bus.out_rd}, 64'd7);
    @(posedge clk);
    #1;
    send(1'b1, 1'b1, 5'd0, 64'hDEAD, 64'h1234);
    check("x0_regwrite", {63'd0, bus.out_regwrite}, 64'd0);
    check("x0_wb_data", bus.out_wb_data, 64'hDEAD);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(1'b1, 1'b0, 5'd10, 64'd0, 64'hA0);
    send(1'b1, 1'b0, 5'd11, 64'd0, 64'hB0);
    check("fl_in_ready_full", {63'd0, bus.in_ready}, 64'd0);
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_rd = 5'd12;
    bus.in_aluresult = 64'hC0;
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    check("fl_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("fl_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("fl_out_regwrite", {63'd0, bus.out_regwrite}, 64'd0);
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("fl_no_reappear", {63'd0, bus.out_valid}, 64'd0);
    bus.out_ready = 1'b0;
    send(1'b1, 1'b0, 5'd13, 64'd0, 64'hD0);
    send(1'b1, 1'b0, 5'd14, 64'd0, 64'hE0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    check("rst_stall_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_stall_in_ready", {63'd0, bus.in_ready}, 64'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    send(1'b1, 1'b0, 5'd3, 64'd0, 64'h33);
    repeat (3) @(posedge clk);
    #1;
`ifdef MEM_WB_STATS_EN
    check("stat_stall", {32'd0, stall_cnt}, 64'd3);
    check("stat_bubble", {32'd0, bubble_cnt}, 64'd2);
`endif
    bus.out_ready = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("stat_flush_out_valid", {63'd0, bus.out_valid}, 64'd0);
`ifdef MEM_WB_STATS_EN
    check("stat_stall_after_flush", {32'd0, stall_cnt}, 64'd3);
    check("stat_bubble_after_flush", {32'd0, bubble_cnt}, 64'd2);
`endif
    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
